// File: rtl/boreal_ledger_pkg.sv
// rtl/boreal_ledger_pkg.sv - shared constants, entry layout and chain hash for the audit ledger
//
// Purpose: one place for everything the ledger top and its RAM agree on.
//   - LEDGER_CHAIN_SEED : chain value before any entry has been accepted
//   - R_IDLE/R_PRESENT  : read FSM encodings
//   - ENTRY_W, *_LSB    : bit layout of one stored entry (MSB first:
//                         seq, opcode, nonce, policy_hash, committed, chain)
//   - ledger_chain_mix  : one step of the running tamper-evidence hash
package boreal_ledger_pkg;

  localparam logic [31:0] LEDGER_CHAIN_SEED = 32'hB0EA_1000;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE    = 1'b0;
  localparam rd_state_t R_PRESENT = 1'b1;

  // Entry layout, 161 bits total.
  localparam int CHAIN_LSB     = 0;
  localparam int COMMITTED_BIT = 32;
  localparam int POLICY_LSB    = 33;
  localparam int NONCE_LSB     = 65;
  localparam int OPCODE_LSB    = 97;
  localparam int SEQ_LSB       = 129;
  localparam int ENTRY_W       = 161;

  // Rotate the previous chain left by 5 and fold in every field of the new
  // entry, so altering, dropping or reordering any stored entry breaks every
  // chain value that follows it.
  function automatic logic [31:0] ledger_chain_mix(
    input logic [31:0] chain,
    input logic [31:0] seq,
    input logic [31:0] opcode,
    input logic [31:0] nonce,
    input logic [31:0] policy_hash,
    input logic        committed
  );
    return {chain[26:0], chain[31:27]} ^ seq ^ opcode ^ nonce ^ policy_hash
           ^ {31'b0, committed};
  endfunction

endpackage

// File: rtl/boreal_ledger_if.sv
// rtl/boreal_ledger_if.sv - write and read handshake bundle of the audit ledger
//
// Purpose: groups the gate-side append port and the auditor-side drain port.
// Ports (signals):
//   ledger_wr_en, wr_opcode, wr_nonce, wr_committed, wr_policy_hash
//                              append request and its fields (gate -> ledger)
//   rd_ready                   auditor accepts the head entry
//   rd_valid, rd_seq, rd_opcode, rd_nonce, rd_policy_hash, rd_committed,
//   rd_chain                   head entry presented by the ledger
// Modports: master = gate/auditor side, slave = ledger side.
interface boreal_ledger_if;

  logic        ledger_wr_en;
  logic [31:0] wr_opcode;
  logic [31:0] wr_nonce;
  logic        wr_committed;
  logic [31:0] wr_policy_hash;

  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_seq;
  logic [31:0] rd_opcode;
  logic [31:0] rd_nonce;
  logic [31:0] rd_policy_hash;
  logic        rd_committed;
  logic [31:0] rd_chain;

  modport master (
    output ledger_wr_en, wr_opcode, wr_nonce, wr_committed, wr_policy_hash,
    output rd_ready,
    input  rd_valid, rd_seq, rd_opcode, rd_nonce, rd_policy_hash,
    input  rd_committed, rd_chain
  );

  modport slave (
    input  ledger_wr_en, wr_opcode, wr_nonce, wr_committed, wr_policy_hash,
    input  rd_ready,
    output rd_valid, rd_seq, rd_opcode, rd_nonce, rd_policy_hash,
    output rd_committed, rd_chain
  );

endinterface

// File: rtl/boreal_ledger_mem.sv
// rtl/boreal_ledger_mem.sv - DEPTH x ENTRY_W simple dual-port entry RAM
//
// Purpose: storage for ledger entries; one write port, one synchronous read
// port whose output register is loaded only when rd_en is high, so the read
// data holds steady between reads.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   AW    write address
//   wr_data  in   ENTRY_W entry to store
//   rd_en    in   load the read register from rd_addr
//   rd_addr  in   AW    read address
//   rd_data  out  ENTRY_W registered read data
module boreal_ledger_mem
  import boreal_ledger_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Array itself has no reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/boreal_ledger.sv
// rtl/boreal_ledger.sv - append-only hash-chained audit ledger with in-order drain
//
// Purpose: every accepted append is stamped with a sequence number and a
// running chain hash and stored in a circular buffer; an auditor drains the
// entries in order. Entries leave only by being read or by reset; writes that
// find the buffer full are dropped and recorded in sticky overflow/drop_count.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-high
//   bus           slave modport of boreal_ledger_if (append + drain handshakes)
//   ledger_count  out  AW+1  entries stored (0..DEPTH)
//   ledger_full   out  registered ledger_count == DEPTH
//   overflow      out  sticky, at least one write dropped
//   drop_count    out  16    dropped writes, saturating
//   chain_head    out  32    chain value of the latest accepted entry
// DEPTH must be a power of two, at least 2; AW is derived and not overridden.
module boreal_ledger
  import boreal_ledger_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  boreal_ledger_if.slave bus,
  output logic [AW:0]   ledger_count,
  output logic          ledger_full,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic [31:0]   chain_head
);

  // DEPTH is a power of two, so it is the MSB alone in an AW+1 wide count.
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  rd_state_t          rd_state;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [31:0]        seq_ctr;
  logic               pop;
  logic               wr_accept;
  logic               rd_en;
  logic [31:0]        chain_next;
  logic [AW:0]        count_next;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;

  assign pop = (rd_state == R_PRESENT) && bus.rd_ready;

  // The presented head entry is still counted, so a write while full is only
  // taken when the head leaves on the same edge; its slot is never clobbered
  // while it is being shown.
  assign wr_accept = bus.ledger_wr_en && ((ledger_count < DEPTH_C) || pop);

  assign rd_en = (rd_state == R_IDLE) && (ledger_count != '0);

  assign chain_next = ledger_chain_mix(chain_head, seq_ctr, bus.wr_opcode,
                                       bus.wr_nonce, bus.wr_policy_hash,
                                       bus.wr_committed);

  assign wr_data = {seq_ctr, bus.wr_opcode, bus.wr_nonce, bus.wr_policy_hash,
                    bus.wr_committed, chain_next};

  always_comb begin
    count_next = ledger_count;
    case ({wr_accept, pop})
      2'b10:   count_next = ledger_count + 1'b1;
      2'b01:   count_next = ledger_count - 1'b1;
      default: count_next = ledger_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      seq_ctr      <= '0;
      chain_head   <= LEDGER_CHAIN_SEED;
      ledger_count <= '0;
      ledger_full  <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        seq_ctr    <= seq_ctr + 32'd1;
        chain_head <= chain_next;
      end else if (bus.ledger_wr_en) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
      ledger_count <= count_next;
      ledger_full  <= (count_next == DEPTH_C);
    end
  end

  // Read FSM: IDLE issues the RAM read, PRESENT holds the registered RAM
  // output as the head entry until the auditor takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
    end else if (rd_state == R_IDLE) begin
      if (rd_en) begin
        rd_state <= R_PRESENT;
      end
    end else if (bus.rd_ready) begin
      rd_ptr   <= rd_ptr + 1'b1;
      rd_state <= R_IDLE;
    end
  end

  boreal_ledger_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.rd_valid       = (rd_state == R_PRESENT);
  assign bus.rd_seq         = rd_data[SEQ_LSB +: 32];
  assign bus.rd_opcode      = rd_data[OPCODE_LSB +: 32];
  assign bus.rd_nonce       = rd_data[NONCE_LSB +: 32];
  assign bus.rd_policy_hash = rd_data[POLICY_LSB +: 32];
  assign bus.rd_committed   = rd_data[COMMITTED_BIT];
  assign bus.rd_chain       = rd_data[CHAIN_LSB +: 32];

endmodule

// File: tb/tb_boreal_ledger.sv
// tb/tb_boreal_ledger.sv - directed self-checking bench for boreal_ledger
module tb_boreal_ledger;

  localparam logic [31:0] SEED     = 32'hB0EA_1000;
  // mix(SEED, 0, 0x11, 1, 0xCAFE, 1) worked by hand
  localparam logic [31:0] CHAIN_E0 = 32'h1D42_CAF9;

  logic        clk;
  logic        rst;
  logic [4:0]  ledger_count;
  logic        ledger_full;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] chain_head;

  boreal_ledger_if bus();

  boreal_ledger dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ledger_count (ledger_count),
    .ledger_full  (ledger_full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .chain_head   (chain_head)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] chain;
    logic [31:0] opcode;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_seq;
  logic [31:0] m_chain;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mix(input logic [31:0] c, input logic [31:0] s,
                                          input logic [31:0] o, input logic [31:0] n,
                                          input logic [31:0] p, input logic cm);
    logic [31:0] r;
    r = (c << 5) | (c >> 27);
    return r ^ s ^ o ^ n ^ p ^ {31'd0, cm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [31:0] op, input logic [31:0] n,
                            input logic [31:0] p, input logic cm);
    exp_t e;
    e.seq    = m_seq;
    e.chain  = ref_mix(m_chain, m_seq, op, n, p, cm);
    e.opcode = op;
    q.push_back(e);
    m_chain = e.chain;
    m_seq   = m_seq + 32'd1;
  endtask

  task automatic drive_wr(input logic [31:0] op, input logic [31:0] n,
                          input logic [31:0] p, input logic cm);
    bus.ledger_wr_en   = 1'b1;
    bus.wr_opcode      = op;
    bus.wr_nonce       = n;
    bus.wr_policy_hash = p;
    bus.wr_committed   = cm;
  endtask

  task automatic write_one(input logic [31:0] op, input logic [31:0] n,
                           input logic [31:0] p, input logic cm);
    drive_wr(op, n, p, cm);
    model_push(op, n, p, cm);
    tick();
    bus.ledger_wr_en = 1'b0;
  endtask

  task automatic write_gen(input int i);
    write_one(32'h0000_0100 + 32'(i), 32'(i * 7 + 3), 32'hCAFE_0000 ^ 32'(i), i[0]);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.ledger_wr_en = 1'b0;
    bus.rd_ready     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    m_seq   = 32'd0;
    m_chain = SEED;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain_one(input string tag);
    logic ok;
    exp_t e;
    wait_valid(ok);
    check({tag, "_vld"}, 32'(ok), 32'd1);
    if (ok && q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_seq"}, bus.rd_seq, e.seq);
      check({tag, "_chain"}, bus.rd_chain, e.chain);
      check({tag, "_op"}, bus.rd_opcode, e.opcode);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic ok;
    int   issued;
    int   got;
    int   mcount;
    exp_t e;

    rst                = 1'b1;
    bus.ledger_wr_en   = 1'b0;
    bus.wr_opcode      = '0;
    bus.wr_nonce       = '0;
    bus.wr_policy_hash = '0;
    bus.wr_committed   = 1'b0;
    bus.rd_ready       = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_count", 32'(ledger_count), 32'd0);
    check("rst_full", 32'(ledger_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_chain", chain_head, SEED);
    check("rst_rdseq", bus.rd_seq, 32'd0);

    // Single entry: write in cycle t, valid in t+2
    write_one(32'h11, 32'h1, 32'hCAFE, 1'b1);
    check("one_cnt_t1", 32'(ledger_count), 32'd1);
    check("one_vld_t1", 32'(bus.rd_valid), 32'd0);
    tick();
    check("one_vld_t2", 32'(bus.rd_valid), 32'd1);
    check("one_seq", bus.rd_seq, 32'd0);
    check("one_chain", bus.rd_chain, CHAIN_E0);
    check("one_op", bus.rd_opcode, 32'h11);
    check("one_nonce", bus.rd_nonce, 32'h1);
    check("one_pol", bus.rd_policy_hash, 32'hCAFE);
    check("one_com", 32'(bus.rd_committed), 32'd1);
    check("one_head", chain_head, CHAIN_E0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("one_cnt_pop", 32'(ledger_count), 32'd0);
    check("one_vld_pop", 32'(bus.rd_valid), 32'd0);

    // Overflow: 16 writes fill, 17th dropped
    do_reset();
    for (int i = 0; i < 16; i++) write_gen(i);
    check("ovf_cnt16", 32'(ledger_count), 32'd16);
    check("ovf_full", 32'(ledger_full), 32'd1);
    check("ovf_pre", 32'(overflow), 32'd0);
    drive_wr(32'hDEAD, 32'hBEEF, 32'h1234, 1'b0);
    tick();
    bus.ledger_wr_en = 1'b0;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(drop_count), 32'd1);
    check("ovf_head", chain_head, m_chain);
    check("ovf_cnt", 32'(ledger_count), 32'd16);
    drain_one("ovf_pop0");
    check("ovf_cnt15", 32'(ledger_count), 32'd15);
    write_gen(16);
    for (int i = 0; i < 16; i++) drain_one($sformatf("ovf_d%0d", i));
    check("ovf_empty", 32'(ledger_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Backpressure: head held 5 cycles, then exactly one pop
    do_reset();
    write_gen(0);
    write_gen(1);
    wait_valid(ok);
    check("bp_vld", 32'(ok), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_vld%0d", k), 32'(bus.rd_valid), 32'd1);
      check($sformatf("bp_seq%0d", k), bus.rd_seq, q[0].seq);
      check($sformatf("bp_chain%0d", k), bus.rd_chain, q[0].chain);
      check($sformatf("bp_op%0d", k), bus.rd_opcode, q[0].opcode);
      tick();
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    void'(q.pop_front());
    check("bp_cnt", 32'(ledger_count), 32'd1);
    check("bp_vld_off", 32'(bus.rd_valid), 32'd0);
    drain_one("bp_d1");
    check("bp_empty", 32'(ledger_count), 32'd0);

    // Full with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 16; i++) write_gen(i);
    wait_valid(ok);
    check("fs_vld", 32'(ok), 32'd1);
    check("fs_seq0", bus.rd_seq, 32'd0);
    drive_wr(32'h0000_0110, 32'h77, 32'hCAFE_0010, 1'b1);
    model_push(32'h0000_0110, 32'h77, 32'hCAFE_0010, 1'b1);
    bus.rd_ready = 1'b1;
    tick();
    bus.ledger_wr_en = 1'b0;
    bus.rd_ready     = 1'b0;
    void'(q.pop_front());
    check("fs_cnt", 32'(ledger_count), 32'd16);
    check("fs_full", 32'(ledger_full), 32'd1);
    check("fs_ovf", 32'(overflow), 32'd0);
    check("fs_drop", 32'(drop_count), 32'd0);
    for (int i = 0; i < 16; i++) drain_one($sformatf("fs_d%0d", i));
    check("fs_empty", 32'(ledger_count), 32'd0);

    // Wrap: 40 writes against random rd_ready, pointers wrap twice
    do_reset();
    issued = 0;
    got    = 0;
    mcount = 0;
    for (int cyc = 0; cyc < 3000 && (issued < 40 || q.size() != 0); cyc++) begin
      bus.rd_ready = 1'($urandom_range(0, 1));
      if (issued < 40 && mcount < 16 && $urandom_range(0, 2) != 0) begin
        drive_wr(32'h0000_0200 + 32'(issued), 32'(issued * 13 + 5),
                 32'h5A5A_0000 ^ 32'(issued), issued[1]);
        model_push(32'h0000_0200 + 32'(issued), 32'(issued * 13 + 5),
                   32'h5A5A_0000 ^ 32'(issued), issued[1]);
        issued++;
        mcount++;
      end else begin
        bus.ledger_wr_en = 1'b0;
      end
      if (bus.rd_valid && bus.rd_ready && q.size() != 0) begin
        e = q.pop_front();
        check($sformatf("wrap_seq%0d", got), bus.rd_seq, e.seq);
        check($sformatf("wrap_chain%0d", got), bus.rd_chain, e.chain);
        mcount--;
        got++;
      end
      tick();
      check("wrap_cnt", 32'(ledger_count), 32'(mcount));
    end
    bus.ledger_wr_en = 1'b0;
    bus.rd_ready     = 1'b0;
    check("wrap_got", 32'(got), 32'd40);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // Reset while presenting with 5 entries stored
    do_reset();
    for (int i = 0; i < 5; i++) write_gen(i);
    wait_valid(ok);
    check("rp_vld", 32'(ok), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    m_seq   = 32'd0;
    m_chain = SEED;
    check("rp_vld_off", 32'(bus.rd_valid), 32'd0);
    check("rp_cnt", 32'(ledger_count), 32'd0);
    check("rp_head", chain_head, SEED);
    check("rp_drop", 32'(drop_count), 32'd0);
    write_one(32'h11, 32'h1, 32'hCAFE, 1'b1);
    wait_valid(ok);
    check("rp_new_vld", 32'(ok), 32'd1);
    check("rp_new_seq", bus.rd_seq, 32'd0);
    check("rp_new_chain", bus.rd_chain, CHAIN_E0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
